ps2_rx_frame: RTL and testbench

PS/2 receive front end: turns the raw keyboard clock/data pins into validated 8-bit scan codes. It synchronises and deglitches the pins, deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop), checks each frame and presents good bytes through a valid/ready port. It sits between the board PS/2 pins and the PS/2 peripheral controller in the system-bus address map. Its `irq_o` drives interrupt line 3 (PS/2).

---
 rtl/ps2_rx_frame.sv | 253 +++++++++++++++++++++++++
 tb/tb_ps2_rx_frame.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame.sv
// PS/2 receive front end: pin sync, clock deglitch, 11-bit frame check, byte storage.
// Define PS2_RX_FIFO_EN for a 4-entry FIFO instead of a single holding register.
module ps2_rx_frame #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       kclk_i,
  input  logic       kdata_i,
  input  logic       ready_i,
  input  logic       clr_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       irq_o,
  output logic       err_o,
  output logic       overflow_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    FL_M1  = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic          r_kclk_s1;
  logic          r_kclk_s2;
  logic          r_kdat_s1;
  logic          r_kdat_s2;
  logic [7:0]    r_fcnt;
  logic          r_filt;
  logic          r_filt_d;
  logic          w_fall;

  state_t        r_state;
  state_t        w_state_n;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_tocnt;
  logic          w_tmo;
  logic          w_shift;
  logic          w_start;
  logic          w_par_en;
  logic          w_push;
  logic          w_err;
  logic          r_err;

  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_ovf;
  logic          r_ovf;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_kclk_s1 <= 1'b1;
      r_kclk_s2 <= 1'b1;
      r_kdat_s1 <= 1'b1;
      r_kdat_s2 <= 1'b1;
    end else begin
      r_kclk_s1 <= kclk_i;
      r_kclk_s2 <= r_kclk_s1;
      r_kdat_s1 <= kdata_i;
      r_kdat_s2 <= r_kdat_s1;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_fcnt   <= '0;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
    end else begin
      r_filt_d <= r_filt;
      if (r_kclk_s2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FL_M1) begin
        r_filt <= r_kclk_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 8'd1;
      end
    end
  end

  assign w_fall = r_filt_d & ~r_filt;

  // A falling edge in the same cycle as expiry keeps the frame alive.
  assign w_tmo = (r_state != S_IDLE) && (r_tocnt == TO_MAX) && !w_fall;

  always_comb begin
    w_state_n = r_state;
    w_start   = 1'b0;
    w_shift   = 1'b0;
    w_par_en  = 1'b0;
    w_push    = 1'b0;
    w_err     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall && !r_kdat_s2) begin
          w_start   = 1'b1;
          w_state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tmo) begin
          w_err     = 1'b1;
          w_state_n = S_IDLE;
        end else if (w_fall) begin
          w_shift = 1'b1;
          if (r_bitcnt == 3'd7) begin
            w_state_n = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (w_tmo) begin
          w_err     = 1'b1;
          w_state_n = S_IDLE;
        end else if (w_fall) begin
          w_par_en  = 1'b1;
          w_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tmo) begin
          w_err     = 1'b1;
          w_state_n = S_IDLE;
        end else if (w_fall) begin
          if ((^r_shift ^ r_par) && r_kdat_s2) begin
            w_push = 1'b1;
          end else begin
            w_err = 1'b1;
          end
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tocnt  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_err   <= w_err;
      if (w_start) begin
        r_bitcnt <= '0;
      end else if (w_shift) begin
        r_bitcnt <= r_bitcnt + 3'd1;
        r_shift  <= {r_kdat_s2, r_shift[7:1]};
      end
      if (w_par_en) begin
        r_par <= r_kdat_s2;
      end
      if (r_state == S_IDLE || w_fall || w_tmo) begin
        r_tocnt <= '0;
      end else begin
        r_tocnt <= r_tocnt + 1'b1;
      end
    end
  end

  assign w_wr  = w_push & (~w_full | w_pop);
  assign w_ovf = w_push & w_full & ~w_pop;

`ifdef PS2_RX_FIFO_EN
  logic [7:0] r_mem [4];
  logic [1:0] r_wp;
  logic [1:0] r_rp;
  logic [2:0] r_cnt;

  assign w_full = (r_cnt == 3'd4);
  assign w_pop  = (r_cnt != 3'd0) & ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= '0;
      end
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= r_shift;
        r_wp        <= r_wp + 2'd1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 2'd1;
      end
      if (w_wr && !w_pop) begin
        r_cnt <= r_cnt + 3'd1;
      end else if (w_pop && !w_wr) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  assign data_o  = r_mem[r_rp];
  assign valid_o = (r_cnt != 3'd0);
`else
  logic [7:0] r_hold;
  logic       r_valid;

  assign w_full = r_valid;
  assign w_pop  = r_valid & ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_hold  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_wr) begin
        r_hold <= r_shift;
      end
      r_valid <= w_wr | (r_valid & ~w_pop);
    end
  end

  assign data_o  = r_hold;
  assign valid_o = r_valid;
`endif

  // A fresh overflow beats a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ovf <= 1'b0;
    end else if (w_ovf) begin
      r_ovf <= 1'b1;
    end else if (clr_i) begin
      r_ovf <= 1'b0;
    end
  end

  assign irq_o      = valid_o;
  assign err_o      = r_err;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: frame table plus timeout,
// glitch, overflow and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_ps2_rx_frame;

  localparam int TMO = 2000;

  logic       clk;
  logic       rst_n;
  logic       kclk;
  logic       kdata;
  logic       ready;
  logic       clr;
  logic [7:0] data;
  logic       valid;
  logic       irq;
  logic       err;
  logic       ovf;

  int total = 0;
  int bad   = 0;
  int n_err = 0;

  ps2_rx_frame #(
    .FILTER_LEN(8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .kclk_i    (kclk),
    .kdata_i   (kdata),
    .ready_i   (ready),
    .clr_i     (clr),
    .data_o    (data),
    .valid_o   (valid),
    .irq_o     (irq),
    .err_o     (err),
    .overflow_o(ovf)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  always @(negedge clk) begin
    if (err === 1'b1) n_err++;
  end

  typedef struct {
    logic [7:0] d;
    logic       par_inv;
    logic       stop;
    int         half;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] fr, input int nb,
                           input int half);
    for (int i = 0; i < nb; i++) begin
      kdata = fr[i];
      cyc(half);
      kclk = 1'b0;
      cyc(half);
      kclk = 1'b1;
    end
    kdata = 1'b1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d,
                                     input logic pinv,
                                     input logic stop);
    logic p;
    p = ~(^d) ^ pinv;
    return {stop, p, d, 1'b0};
  endfunction

  task automatic send(input logic [7:0] d, input int half);
    send_bits(mk(d, 1'b0, 1'b1), 11, half);
    cyc(30);
  endtask

  // Pops one byte; data is sampled before the popping edge.
  task automatic pop(input string name, input logic [7:0] exp);
    int w;
    w = 0;
    while (valid !== 1'b1 && w < 100) begin
      cyc(1);
      w++;
    end
    chk({name, "_avail"}, 32'(valid), 32'd1);
    @(negedge clk);
    chk({name, "_data"}, 32'(data), 32'(exp));
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    int e0;
    rst_n = 1'b0;
    kclk  = 1'b1;
    kdata = 1'b1;
    ready = 1'b0;
    clr   = 1'b0;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 150, 1'b1, 8'h1C, 0};
    vecs[1] = '{8'h5A, 1'b1, 1'b1, 20,  1'b0, 8'h00, 1};
    vecs[2] = '{8'hF0, 1'b0, 1'b1, 20,  1'b1, 8'hF0, 0};
    vecs[3] = '{8'h29, 1'b0, 1'b0, 20,  1'b0, 8'h00, 1};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 20,  1'b1, 8'h00, 0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 11,  1'b1, 8'hFF, 0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 20,  1'b0, 8'h00, 1};
    vecs[7] = '{8'hA5, 1'b0, 1'b1, 20,  1'b1, 8'hA5, 0};

    cyc(3);
    @(negedge clk);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(5);

    for (int i = 0; i < 8; i++) begin
      e0 = n_err;
      send_bits(mk(vecs[i].d, vecs[i].par_inv, vecs[i].stop), 11,
                vecs[i].half);
      cyc(30);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_irq", i), 32'(irq), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_err", i), 32'(n_err - e0), 32'(vecs[i].exp_err));
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
        @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_popped", i), 32'(valid), 32'd0);
      end
      cyc(5);
    end

    // Timeout after start + 4 data bits, then a clean frame.
    e0 = n_err;
    send_bits(mk(8'hC3, 1'b0, 1'b1), 5, 20);
    cyc(TMO + 10);
    chk("tmo_err", 32'(n_err - e0), 32'd1);
    chk("tmo_valid", 32'(valid), 32'd0);
    send(8'hF0, 20);
    chk("tmo_err2", 32'(n_err - e0), 32'd1);
    pop("tmo", 8'hF0);
    @(negedge clk);
    chk("tmo_only", 32'(valid), 32'd0);

    // Short low glitch with data low must not start a frame.
    e0 = n_err;
    kdata = 1'b0;
    kclk  = 1'b0;
    cyc(3);
    kclk  = 1'b1;
    kdata = 1'b1;
    cyc(30);
    chk("gl_valid", 32'(valid), 32'd0);
    send(8'h29, 20);
    pop("gl", 8'h29);
    @(negedge clk);
    chk("gl_only", 32'(valid), 32'd0);
    chk("gl_err", 32'(n_err - e0), 32'd0);

`ifdef PS2_RX_FIFO_EN
    for (int b = 1; b <= 5; b++) begin
      send(8'(b), 20);
    end
    @(negedge clk);
    chk("ovf_set", 32'(ovf), 32'd1);
    for (int b = 1; b <= 4; b++) begin
      pop($sformatf("fifo%0d", b), 8'(b));
    end
    @(negedge clk);
    chk("fifo_empty", 32'(valid), 32'd0);
`else
    send(8'h11, 20);
    send(8'h22, 20);
    @(negedge clk);
    chk("ovf_data", 32'(data), 32'h11);
    chk("ovf_set", 32'(ovf), 32'd1);
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("ovf_clr", 32'(ovf), 32'd0);
    pop("ovf", 8'h11);
    @(negedge clk);
    chk("ovf_empty", 32'(valid), 32'd0);
`endif

    // Reset mid-frame with a byte already stored.
    send(8'h44, 20);
    e0 = n_err;
    send_bits(mk(8'h77, 1'b0, 1'b1), 6, 20);
    rst_n = 1'b0;
    cyc(2);
    @(negedge clk);
    chk("mr_data", 32'(data), 32'h00);
    chk("mr_valid", 32'(valid), 32'd0);
    chk("mr_irq", 32'(irq), 32'd0);
    chk("mr_err", 32'(err), 32'd0);
    chk("mr_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(5);
    send(8'h3A, 20);
    pop("mr", 8'h3A);
    @(negedge clk);
    chk("mr_only", 32'(valid), 32'd0);
    chk("mr_noerr", 32'(n_err - e0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
